// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-cycle SRAM port with registered ack/rdata routing.
// Optional MEM_ARB_RR_EN selects round-robin contention handling instead of data priority with starvation limit.
module mem_arbiter #(
    parameter int MEM_AW     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [3:0]        m_be,
    output logic [MEM_AW-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_IFETCH = 2'd1,
        OWN_DATA   = 2'd2
    } owner_e;

    owner_e      owner_q, owner_d;
    logic        store_q, store_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        contend;

`ifdef MEM_ARB_RR_EN
    // 1 means fetch wins the next contention cycle; reset favours data.
    logic rr_ptr_q, rr_ptr_d;
`else
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    logic [SW-1:0] starve_q, starve_d;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:MEM_AW+2], i_addr[1:0],
                                d_addr[31:MEM_AW+2], d_addr[1:0]};

    assign contend = i_req && d_req;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q   <= OWN_NONE;
            store_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            rr_ptr_q  <= 1'b0;
`else
            starve_q  <= '0;
`endif
        end else begin
            owner_q   <= owner_d;
            store_q   <= store_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
            rr_ptr_q  <= rr_ptr_d;
`else
            starve_q  <= starve_d;
`endif
        end
    end

    // Grant decision and next-state
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (contend) begin
`ifdef MEM_ARB_RR_EN
                i_gnt = rr_ptr_q;
`else
                i_gnt = (starve_q == STARVE_LIM);
`endif
                d_gnt = !i_gnt;
            end else begin
                i_gnt = i_req;
                d_gnt = d_req;
            end
        end

        if (i_gnt) begin
            owner_d = OWN_IFETCH;
        end else if (d_gnt) begin
            owner_d = OWN_DATA;
        end else begin
            owner_d = OWN_NONE;
        end
        store_d = d_gnt && d_we;

`ifdef MEM_ARB_RR_EN
        rr_ptr_d = rr_ptr_q;
        if (contend && !rst) begin
            rr_ptr_d = !i_gnt;
        end
`else
        starve_d = '0;
        if (i_req && !i_gnt) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + SW'(1);
        end
`endif
    end

    // Memory port and response outputs
    always_comb begin
        m_en    = i_gnt || d_gnt;
        m_we    = 1'b0;
        m_be    = 4'b0000;
        m_addr  = '0;
        m_wdata = '0;
        if (d_gnt) begin
            m_we    = d_we;
            m_be    = d_be;
            m_addr  = d_addr[MEM_AW+1:2];
            m_wdata = d_wdata;
        end else if (i_gnt) begin
            m_be    = 4'b1111;
            m_addr  = i_addr[MEM_AW+1:2];
        end

        i_ack   = !rst && (owner_q == OWN_IFETCH);
        d_ack   = !rst && (owner_q == OWN_DATA);
        i_rdata = i_rdata_q;
        d_rdata = d_rdata_q;
        if (rst) begin
            i_rdata = '0;
            d_rdata = '0;
        end else begin
            if (i_ack) begin
                i_rdata = m_rdata;
            end
            // A completed store leaves the load data untouched.
            if (d_ack && !store_q) begin
                d_rdata = m_rdata;
            end
        end
        i_rdata_d = i_rdata;
        d_rdata_d = d_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural 1-cycle SRAM model.
// Expected acks are queued when a grant is driven and matched one cycle later.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt, i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_ack;
    logic [31:0] d_rdata;
    logic        m_en, m_we;
    logic [3:0]  m_be;
    logic [15:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;

    mem_arbiter #(.MEM_AW(16), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_ack(d_ack), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    logic [31:0] exp_d_hold = '0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [int];

    function automatic logic [31:0] mem_rd(input int a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    always @(posedge clk) begin : sram
        logic [31:0] w;
        int a;
        a = int'(m_addr);
        if (m_en === 1'b1) begin
            if (m_we) begin
                w = mem_rd(a);
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
                mem[a] = w;
            end else begin
                m_rdata <= mem_rd(a);
            end
        end
    end

    typedef struct {
        logic        is_d;
        logic [31:0] data;
        int          cyc;
    } sb_t;
    sb_t sbq[$];

    task automatic sb_push(input logic is_d, input logic [31:0] data);
        sb_t e;
        e.is_d = is_d;
        e.data = data;
        e.cyc  = cyc;
        sbq.push_back(e);
    endtask

    // Ack/rdata scoreboard, sampled on the falling edge.
    always @(negedge clk) begin : monitor
        sb_t e;
        logic [31:0] got;
        if (sbq.size() > 0 && sbq[0].cyc + 1 == cyc) begin
            e = sbq.pop_front();
            n_total++;
            if ({i_ack, d_ack} !== (e.is_d ? 2'b01 : 2'b10))
                $display("FAIL ack_route cyc=%0d got i/d_ack=%b required=%b", cyc, {i_ack, d_ack},
                         e.is_d ? 2'b01 : 2'b10);
            else n_pass++;
            got = e.is_d ? d_rdata : i_rdata;
            n_total++;
            if (got !== e.data)
                $display("FAIL rdata_%s cyc=%0d got=%h required=%h", e.is_d ? "d" : "i", cyc, got, e.data);
            else n_pass++;
        end else begin
            n_total++;
            if ({i_ack, d_ack} !== 2'b00)
                $display("FAIL spurious_ack cyc=%0d got i/d_ack=%b required=00", cyc, {i_ack, d_ack});
            else n_pass++;
        end
    end

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [3:0] db, input logic [31:0] da, input logic [31:0] dd);
        @(posedge clk);
        #1;
        i_req = ir; i_addr = ia;
        d_req = dr; d_we = dw; d_be = db; d_addr = da; d_wdata = dd;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    function automatic logic exp_data_wins(input int k);
`ifdef MEM_ARB_RR_EN
        return (k % 2) == 0;
`else
        return k != 4;
`endif
    endfunction

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h44, 1'b1, 1'b1, 4'hF, 32'h2000, 32'h55);
            #2;
            n_total++;
            if ({i_gnt, d_gnt, m_en, m_we, i_ack, d_ack} !== 6'b0)
                $display("FAIL reset_force got=%b required=000000", {i_gnt, d_gnt, m_en, m_we, i_ack, d_ack});
            else n_pass++;
        end
        idle();
        rst = 1'b0;
        #2;
        n_total++;
        if ({i_rdata, d_rdata} !== 64'h0)
            $display("FAIL reset_rdata got=%h required=0", {i_rdata, d_rdata});
        else n_pass++;
        exp_d_hold = 32'h0;
    endtask

    task automatic test_fetch();
        drive(1'b1, 32'h44, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #2;
        n_total++;
        if ({i_gnt, d_gnt, m_en, m_we, m_be, m_addr} !== {4'b1010, 4'hF, 16'h0011})
            $display("FAIL fetch_grant got=%b/%h/%h required=1010/f/0011",
                     {i_gnt, d_gnt, m_en, m_we}, m_be, m_addr);
        else n_pass++;
        sb_push(1'b0, 32'h00000013);
        idle();
        #2;
        n_total++;
        if ({i_gnt, d_gnt, m_en} !== 3'b000)
            $display("FAIL idle_grant got=%b required=000", {i_gnt, d_gnt, m_en});
        else n_pass++;
        idle();
        #2;
        n_total++;
        if (i_rdata !== 32'h00000013)
            $display("FAIL i_rdata_hold got=%h required=00000013", i_rdata);
        else n_pass++;
    endtask

    task automatic test_store_load();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h2000, 32'hDEADBEEF);
        #2;
        n_total++;
        if ({i_gnt, d_gnt, m_we, m_be, m_addr, m_wdata} !== {3'b011, 4'hF, 16'h0800, 32'hDEADBEEF})
            $display("FAIL store_port got=%b/%h/%h/%h required=011/f/0800/deadbeef",
                     {i_gnt, d_gnt, m_we}, m_be, m_addr, m_wdata);
        else n_pass++;
        sb_push(1'b1, exp_d_hold);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0);
        #2;
        n_total++;
        if ({d_gnt, m_we, m_addr} !== {2'b10, 16'h0800})
            $display("FAIL load_port got=%b/%h required=10/0800", {d_gnt, m_we}, m_addr);
        else n_pass++;
        sb_push(1'b1, 32'hDEADBEEF);
        exp_d_hold = 32'hDEADBEEF;
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h2000, 32'h0000BEEF);
        #2;
        n_total++;
        if (m_be !== 4'b0011)
            $display("FAIL partial_be got=%b required=0011", m_be);
        else n_pass++;
        sb_push(1'b1, exp_d_hold);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0);
        sb_push(1'b1, 32'hDEADBEEF);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b1100, 32'h2001, 32'h12340000);
        sb_push(1'b1, 32'hDEADBEEF);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h2003, 32'h0);
        sb_push(1'b1, 32'h1234BEEF);
        exp_d_hold = 32'h1234BEEF;
        idle();
    endtask

    task automatic test_contention();
        logic dw;
        for (int burst = 0; burst < 2; burst++) begin
            for (int k = 0; k < (burst == 0 ? 6 : 5); k++) begin
                drive(1'b1, 32'h44, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
                #2;
                dw = exp_data_wins(k);
                n_total++;
                if ({i_gnt, d_gnt} !== {!dw, dw})
                    $display("FAIL contend_b%0d_k%0d got i/d_gnt=%b required=%b", burst, k,
                             {i_gnt, d_gnt}, {!dw, dw});
                else n_pass++;
                if (dw) begin
                    sb_push(1'b1, 32'hCAFEF00D);
                    exp_d_hold = 32'hCAFEF00D;
                end else begin
                    sb_push(1'b0, 32'h00000013);
                end
            end
            idle();
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        sb_push(1'b0, 32'h00A0A0A0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0);
        #2;
        n_total++;
        if ({i_gnt, d_gnt, i_ack} !== 3'b011)
            $display("FAIL b2b_overlap got gnt/ack=%b required=011", {i_gnt, d_gnt, i_ack});
        else n_pass++;
        sb_push(1'b1, 32'h1234BEEF);
        exp_d_hold = 32'h1234BEEF;
        drive(1'b1, 32'h44, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        sb_push(1'b0, 32'h00000013);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h3000, 32'h77777777);
        sb_push(1'b1, exp_d_hold);
        idle();
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        #2;
        n_total++;
        if (d_gnt !== 1'b1)
            $display("FAIL rmid_grant got=%b required=1", d_gnt);
        else n_pass++;
        drive(1'b1, 32'h44, 1'b1, 1'b1, 4'hF, 32'h10, 32'h99);
        rst = 1'b1;
        #2;
        n_total++;
        if ({i_gnt, i_ack, i_rdata, d_gnt, d_ack, d_rdata, m_en, m_we, m_be, m_addr, m_wdata} !== '0)
            $display("FAIL rmid_outputs got=%b/%h/%h/%h/%h required=all zero",
                     {i_gnt, i_ack, d_gnt, d_ack, m_en, m_we}, i_rdata, d_rdata, m_addr, m_wdata);
        else n_pass++;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        rst = 1'b0;
        #2;
        n_total++;
        if ({d_gnt, m_en, m_addr} !== {2'b11, 16'h0004})
            $display("FAIL rmid_first_grant got=%b/%h required=11/0004", {d_gnt, m_en}, m_addr);
        else n_pass++;
        sb_push(1'b1, 32'hCAFEF00D);
        exp_d_hold = 32'hCAFEF00D;
        idle();
        #2;
        n_total++;
        if (i_rdata !== 32'h0)
            $display("FAIL rmid_i_rdata got=%h required=0", i_rdata);
        else n_pass++;
    endtask

    initial begin
        mem[32'h11] = 32'h00000013;
        mem[32'h04] = 32'hCAFEF00D;
        mem[32'h20] = 32'h00A0A0A0;
        test_reset();
        test_fetch();
        test_store_load();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        idle();
        idle();
        n_total++;
        if (sbq.size() !== 0)
            $display("FAIL sb_drain got=%0d pending required=0", sbq.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
